// File: rtl/banco_registradores_pkg.sv
// Shared register-file constants and types; also used by the writeback destination mux.
package banco_registradores_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int NUM_REGS       = 32;
    localparam int IDX_WIDTH      = 5;

    localparam logic [IDX_WIDTH-1:0] REG_ZERO        = 5'd0;
    localparam logic [IDX_WIDTH-1:0] REG_SP          = 5'd29;
    localparam logic [IDX_WIDTH-1:0] REG_KERNEL_ADDR = 5'b11001;
    localparam logic [IDX_WIDTH-1:0] REG_ADDRESS     = 5'b11111;

    localparam logic [DATA_WIDTH_DEF-1:0] SP_INIT_DEF = 32'h0000_3FFC;

    typedef logic [IDX_WIDTH-1:0] reg_idx_t;

    typedef struct packed {
        logic haz_a;
        logic haz_b;
        logic haz_w;
    } hazards_t;

    // True when a writeback in flight this cycle targets 'idx' (bypass / hazard resolution).
    function automatic logic escrita_atinge(input logic en, input reg_idx_t dest,
                                            input reg_idx_t idx);
        return en && (dest == idx) && (idx != REG_ZERO);
    endfunction

endpackage

// File: rtl/placar_registradores.sv
// Pending-write scoreboard: one bit per register, set on reservation, cleared on writeback.
module placar_registradores
    import banco_registradores_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic [4:0]    rs,
    input  logic [4:0]    rt,
    input  logic          usa_rs,
    input  logic          usa_rt,
    input  logic          escreve_reg,
    input  logic [4:0]    reg_escrito,
    input  logic          reserva_reg,
    input  logic [4:0]    reg_reservado,
    output logic          stall,
    output logic [31:0]   pendentes
);

    hazards_t       haz;
    logic [31:0]    pendentes_next;
    logic           limpa;
    logic           marca;

    always_comb begin
        haz.haz_a = usa_rs && (rs != REG_ZERO) && pendentes[rs]
                    && !escrita_atinge(escreve_reg, reg_escrito, rs);
        haz.haz_b = usa_rt && (rt != REG_ZERO) && pendentes[rt]
                    && !escrita_atinge(escreve_reg, reg_escrito, rt);
        haz.haz_w = reserva_reg && (reg_reservado != REG_ZERO) && pendentes[reg_reservado]
                    && !escrita_atinge(escreve_reg, reg_escrito, reg_reservado);
        stall     = reset && (haz.haz_a || haz.haz_b || haz.haz_w);
    end

    // Set is applied after clear so a new producer keeps ownership of the register.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        pendentes_next = pendentes;
        limpa          = escreve_reg && (reg_escrito != REG_ZERO);
        marca          = reserva_reg && (reg_reservado != REG_ZERO) && !stall;
        if (limpa) pendentes_next[reg_escrito]   = 1'b0;
        if (marca) pendentes_next[reg_reservado] = 1'b1;
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together.
        if (!reset) pendentes <= '0;
        else        pendentes <= pendentes_next;
    end

endmodule

// File: rtl/banco_registradores.sv
// 32-entry register file with write-to-read bypass, hardwired $zero and an integrated scoreboard.
module banco_registradores
    import banco_registradores_pkg::*;
#(
    parameter int                    DATA_WIDTH = DATA_WIDTH_DEF,
    parameter logic [DATA_WIDTH-1:0] SP_INIT    = SP_INIT_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [4:0]            RS,
    input  logic [4:0]            RT,
    input  logic                  usaRS,
    input  logic                  usaRT,
    output logic [DATA_WIDTH-1:0] dadoRS,
    output logic [DATA_WIDTH-1:0] dadoRT,
    input  logic                  escreveReg,
    input  logic [4:0]            regEscrito,
    input  logic [DATA_WIDTH-1:0] dadoEscrito,
    input  logic                  reservaReg,
    input  logic [4:0]            regReservado,
    output logic                  stall,
    output logic [31:0]           pendentes
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // Reg 0 is never written, so its flops hold the reset value of zero forever.
    always_ff @(posedge clock) begin
        if (!reset) begin
            // NOTE: this array is reset explicitly because $sp must come up at SP_INIT and the
            // rest at zero; plain storage arrays are normally left unreset.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= (reg_idx_t'(i) == REG_SP) ? SP_INIT : '0;
            end
        end else if (escreveReg && (regEscrito != REG_ZERO)) begin
            regs[regEscrito] <= dadoEscrito;
        end
    end

    always_comb begin
        dadoRS = regs[RS];
        if (RS == REG_ZERO)                                  dadoRS = '0;
        else if (escrita_atinge(escreveReg, regEscrito, RS)) dadoRS = dadoEscrito;

        dadoRT = regs[RT];
        if (RT == REG_ZERO)                                  dadoRT = '0;
        else if (escrita_atinge(escreveReg, regEscrito, RT)) dadoRT = dadoEscrito;
    end

    placar_registradores u_placar (
        .clock         (clock),
        .reset         (reset),
        .rs            (RS),
        .rt            (RT),
        .usa_rs        (usaRS),
        .usa_rt        (usaRT),
        .escreve_reg   (escreveReg),
        .reg_escrito   (regEscrito),
        .reserva_reg   (reservaReg),
        .reg_reservado (regReservado),
        .stall         (stall),
        .pendentes     (pendentes)
    );

endmodule

// File: tb/tb_banco_registradores.sv
// Directed bench for banco_registradores: reset contents, bypass, $zero, scoreboard stalls.
module tb_banco_registradores;

    logic        clock;
    logic        reset;
    logic [4:0]  RS, RT;
    logic        usaRS, usaRT;
    logic [31:0] dadoRS, dadoRT;
    logic        escreveReg;
    logic [4:0]  regEscrito;
    logic [31:0] dadoEscrito;
    logic        reservaReg;
    logic [4:0]  regReservado;
    logic        stall;
    logic [31:0] pendentes;

    int checks = 0;
    int errors = 0;

    banco_registradores dut (
        .clock        (clock),
        .reset        (reset),
        .RS           (RS),
        .RT           (RT),
        .usaRS        (usaRS),
        .usaRT        (usaRT),
        .dadoRS       (dadoRS),
        .dadoRT       (dadoRT),
        .escreveReg   (escreveReg),
        .regEscrito   (regEscrito),
        .dadoEscrito  (dadoEscrito),
        .reservaReg   (reservaReg),
        .regReservado (regReservado),
        .stall        (stall),
        .pendentes    (pendentes)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then return at the following falling edge for new stimulus.
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle();
        usaRS = 0; usaRT = 0; escreveReg = 0; reservaReg = 0;
        regEscrito = 0; regReservado = 0; dadoEscrito = 0;
    endtask

    initial begin
        reset = 0; RS = 0; RT = 0;
        idle();
        step();
        step();

        // Reset contents and scoreboard state.
        usaRS = 1; usaRT = 1; reservaReg = 1; regReservado = 5'd8;
        #1;
        check("reset_pendentes", pendentes, 32'h0);
        check("reset_stall", {31'b0, stall}, 32'h0);
        idle();
        for (int i = 0; i < 32; i++) begin
            RS = 5'(i);
            RT = 5'(31 - i);
            #1;
            check($sformatf("reset_rs_%0d", i), dadoRS, (i == 29) ? 32'h0000_3FFC : 32'h0);
            check($sformatf("reset_rt_%0d", 31 - i), dadoRT,
                  ((31 - i) == 29) ? 32'h0000_3FFC : 32'h0);
        end
        @(negedge clock);
        reset = 1;
        step();

        // Same-cycle bypass, then stored value on the next cycle.
        escreveReg = 1; regEscrito = 5'd5; dadoEscrito = 32'hDEAD_BEEF; RS = 5'd5; RT = 5'd6;
        #1;
        check("bypass_rs_same_cycle", dadoRS, 32'hDEAD_BEEF);
        check("bypass_rt_other_reg", dadoRT, 32'h0);
        step();
        idle();
        RT = 5'd5;
        #1;
        check("stored_rs_next_cycle", dadoRS, 32'hDEAD_BEEF);
        check("stored_rt_next_cycle", dadoRT, 32'hDEAD_BEEF);

        // Write to $zero is ignored, never marked pending.
        escreveReg = 1; regEscrito = 5'd0; dadoEscrito = 32'hFFFF_FFFF; RS = 5'd0;
        #1;
        check("zero_read_during_write", dadoRS, 32'h0);
        step();
        idle();
        #1;
        check("zero_read_after_write", dadoRS, 32'h0);
        check("zero_never_pending", pendentes, 32'h0);

        // Unreserved kernel write to reg 25.
        escreveReg = 1; regEscrito = 5'd25; dadoEscrito = 32'h8000_0180;
        step();
        idle();
        RT = 5'd25;
        #1;
        check("kernel_write_reg25", dadoRT, 32'h8000_0180);
        check("kernel_write_no_pending", pendentes, 32'h0);

        // Reserve reg 8, then a consumer of RS=8 stalls until writeback.
        reservaReg = 1; regReservado = 5'd8;
        #1;
        check("reserve8_no_stall", {31'b0, stall}, 32'h0);
        step();
        idle();
        usaRS = 1; RS = 5'd8;
        #1;
        check("raw_rs_stall", {31'b0, stall}, 32'h1);
        check("reserve8_pending", pendentes, 32'h0000_0100);
        step();
        #1;
        check("raw_rs_stall_held", {31'b0, stall}, 32'h1);
        usaRS = 0; usaRT = 1; RT = 5'd8;
        #1;
        check("raw_rt_stall", {31'b0, stall}, 32'h1);
        usaRT = 0; usaRS = 1;
        escreveReg = 1; regEscrito = 5'd8; dadoEscrito = 32'h1234_5678;
        #1;
        check("raw_resolved_by_write", {31'b0, stall}, 32'h0);
        check("raw_bypass_data", dadoRS, 32'h1234_5678);
        step();
        escreveReg = 0;
        #1;
        check("clear8_pending", pendentes, 32'h0);
        check("clear8_no_stall", {31'b0, stall}, 32'h0);
        check("reg8_stored", dadoRS, 32'h1234_5678);
        idle();

        // WAW: second reservation of a pending register stalls and is not taken.
        reservaReg = 1; regReservado = 5'd8;
        step();
        #1;
        check("waw_stall", {31'b0, stall}, 32'h1);
        step();
        #1;
        check("waw_pending_unchanged", pendentes, 32'h0000_0100);
        escreveReg = 1; regEscrito = 5'd8; dadoEscrito = 32'h0000_0042;
        #1;
        check("waw_resolved_by_write", {31'b0, stall}, 32'h0);
        step();
        idle();
        #1;
        check("set_wins_over_clear", pendentes, 32'h0000_0100);

        // Reservation of $zero is a no-op.
        reservaReg = 1; regReservado = 5'd0;
        #1;
        check("reserve_zero_no_stall", {31'b0, stall}, 32'h0);
        step();
        idle();
        #1;
        check("reserve_zero_no_effect", pendentes, 32'h0000_0100);

        // Retire 8 while reserving 3, then reserve 31.
        escreveReg = 1; regEscrito = 5'd8; dadoEscrito = 32'h0000_0043;
        reservaReg = 1; regReservado = 5'd3;
        step();
        idle();
        reservaReg = 1; regReservado = 5'd31;
        step();
        idle();
        #1;
        check("pending_3_and_31", pendentes, 32'h8000_0008);

        // Mid-flight reset: write and reservation discarded, stall forced low.
        reset = 0;
        escreveReg = 1; regEscrito = 5'd3; dadoEscrito = 32'h0000_AAAA;
        reservaReg = 1; regReservado = 5'd31; usaRS = 1; RS = 5'd31;
        #1;
        check("reset_forces_stall_low", {31'b0, stall}, 32'h0);
        step();
        idle();
        RS = 5'd3; RT = 5'd29;
        #1;
        check("midreset_pendentes", pendentes, 32'h0);
        check("midreset_reg3", dadoRS, 32'h0);
        check("midreset_sp", dadoRT, 32'h0000_3FFC);
        check("midreset_stall", {31'b0, stall}, 32'h0);
        reset = 1;
        RS = 5'd8;
        #1;
        check("midreset_reg8_cleared", dadoRS, 32'h0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
